dcim_psum_accumulator: RTL and testbench
========================================

DCIM_PSUM_ACCUMULATOR -- requirements
Module: dcim_psum_accumulator

Interface
REQ-001 Parameter PROD_WIDTH, default 32, width of the incoming product word.
REQ-002 Parameter ACC_WIDTH, default 40, width of the accumulator and of the sum output.
REQ-003 Parameter LEN_WIDTH, default 6, width of the window-length input.
REQ-004 Parameter MAX_LEN, default 32, largest window length.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port pe_ce, input, 1 bit: stage enable; samples are accepted only while high.
REQ-008 Port init_done, input, 1 bit: upstream multiplier array has finished weight load and is running.
REQ-009 Port valid_in, input, 1 bit: product_in is valid this cycle.
REQ-010 Port product_in, input, PROD_WIDTH bits: unsigned product from the upstream SRAM-multiplier stage.
REQ-011 Port acc_len, input, LEN_WIDTH bits: products per window.
REQ-012 Port acc_clear, input, 1 bit: synchronous flush.
REQ-013 Port sum_valid, output, 1 bit: sum_out holds a completed window sum.
REQ-014 Port sum_ready, input, 1 bit: the consumer accepts sum_out this cycle.
REQ-015 Port sum_out, output, ACC_WIDTH bits: completed window sum.
REQ-016 Port overrun, output, 1 bit: sticky flag; a completed sum was dropped.
REQ-017 Port win_count, output, 16 bits: completed windows pushed, wraps modulo 2^16.

Function
REQ-018 A sample SHALL be accepted when valid_in, pe_ce and init_done are all high and acc_clear is low.
REQ-019 States SHALL be IDLE (no partial window) and ACCUM (partial window open).
- IDLE -> ACCUM on an accepted sample when the effective length is > 1.
- ACCUM -> IDLE on the accepted sample that completes the window.
REQ-020 The effective length SHALL be latched at the first sample of each window.
- acc_len = 0 is treated as 1.
- acc_len > MAX_LEN is clamped to MAX_LEN.
- Changes to acc_len mid-window have no effect on the open window.
REQ-021 The first sample of a window SHALL load the accumulator with zero-extended product_in; each later sample adds product_in to it.
REQ-022 The add SHALL be an unsigned ACC_WIDTH add with no saturation; 32 x (2^32-1) fits without overflow.
REQ-023 On the completing sample, acc+product_in SHALL be pushed into a 2-entry output FIFO in the same cycle.
- The sample counter returns to 0.
- win_count increments.
REQ-024 Latency SHALL be one cycle: completion at edge N gives sum_valid high after edge N when the FIFO was empty.
REQ-025 sum_valid SHALL be high when the FIFO is non-empty, and sum_out SHALL show the FIFO head.
REQ-026 A pop SHALL occur when sum_valid and sum_ready are both high.
- sum_out and sum_valid remain stable while sum_valid is high and sum_ready is low.
REQ-027 A simultaneous push and pop on a full FIFO SHALL succeed and leave occupancy at 2.
REQ-028 A push to a full FIFO without a pop SHALL discard the new sum.
- overrun is set.
- win_count still increments.
REQ-029 acc_clear high SHALL:
- discard the partial window and flush the FIFO;
- clear overrun;
- return to IDLE.
- It has priority over a same-cycle sample, which is discarded; win_count is unaffected.
REQ-030 init_done low while in ACCUM SHALL discard the partial window and return to IDLE; FIFO contents are kept.
REQ-031 When pe_ce is low, the accumulator state SHALL hold; the output handshake keeps operating.

Reset
REQ-032 While rst_n is low:
- the state is IDLE and the accumulator, counter and latched length are 0;
- the FIFO is empty, so sum_valid = 0 and sum_out = 0;
- overrun = 0 and win_count = 0.
REQ-033 Reset assertion mid-window SHALL abandon all partial and buffered data immediately, without waiting for a clock edge.

Structure
REQ-034 The state encoding, PROD_WIDTH, ACC_WIDTH, LEN_WIDTH and MAX_LEN defaults SHALL live in the shared package dcim_pkg.
REQ-035 The output FIFO SHALL be a separate sub-module, dcim_sum_fifo, with depth 2, async active-low reset and a push/pop/full/empty interface.

Verification
REQ-036 acc_len=4, products 1, 2, 3, 4 on consecutive cycles, sum_ready=1 -> sum_out=10 with sum_valid high for exactly one cycle, one cycle after the 4th sample; win_count=1.
REQ-037 acc_len=32, 32 products of 0xFFFFFFFF -> sum_out=0x1FFFFFFFE0.
REQ-038 acc_len=1, sum_ready=0, three samples 5, 6, 7 -> FIFO holds 5 and 6, 7 is dropped, overrun=1, win_count=3; then sum_ready=1 -> 5, then 6.
REQ-039 acc_len=4, three samples, then acc_clear together with a 4th sample -> no output, state IDLE; next 4 samples of 1 -> sum_out=4.
REQ-040 acc_len changed from 4 to 2 after the 2nd sample -> the window still closes after 4 samples; the next window closes after 2.
REQ-041 rst_n pulsed low mid-window with FIFO occupancy 1 -> sum_valid, overrun and win_count all 0 before the next clock edge.

Source files
------------

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM partial-sum accumulator slice.
// Latency: n/a (types and default parameters only).
// Backpressure: n/a.
package dcim_pkg;

    localparam int PROD_WIDTH_DEF = 32;
    localparam int ACC_WIDTH_DEF  = 40;
    localparam int LEN_WIDTH_DEF  = 6;
    localparam int MAX_LEN_DEF    = 32;

    // IDLE: no partial window open; ACCUM: partial window open.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

endpackage : dcim_pkg

// File: rtl/dcim_psum_accumulator_if.sv
// Product-in / sum-out bundle between the multiplier array, the accumulator and its consumer.
// Latency: n/a (wiring only).
// Backpressure: sum_valid/sum_ready handshake on the output side; input side has no ready.
// Ports (slave view): pe_ce, init_done, valid_in, product_in, acc_len, acc_clear, sum_ready in;
//                     sum_valid, sum_out, overrun, win_count out.
interface dcim_psum_accumulator_if
    import dcim_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);
    logic                  pe_ce;
    logic                  init_done;
    logic                  valid_in;
    logic [PROD_WIDTH-1:0] product_in;
    logic [LEN_WIDTH-1:0]  acc_len;
    logic                  acc_clear;
    logic                  sum_valid;
    logic                  sum_ready;
    logic [ACC_WIDTH-1:0]  sum_out;
    logic                  overrun;
    logic [15:0]           win_count;

    // Upstream/consumer side.
    modport master (
        output pe_ce, init_done, valid_in, product_in, acc_len, acc_clear, sum_ready,
        input  sum_valid, sum_out, overrun, win_count
    );

    // Accumulator side.
    modport slave (
        input  pe_ce, init_done, valid_in, product_in, acc_len, acc_clear, sum_ready,
        output sum_valid, sum_out, overrun, win_count
    );

endinterface : dcim_psum_accumulator_if

// File: rtl/dcim_sum_fifo.sv
// Two-entry output FIFO holding completed window sums.
// Latency: one cycle push-to-visible; head shown combinationally (zero when empty).
// Backpressure: push while full is taken only together with a pop, otherwise dropped.
// Ports: clk, rst_n, i_flush, i_push, i_pop, i_data in; o_data, o_full, o_empty out.
module dcim_sum_fifo #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_cnt;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_cnt == 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign w_pop   = i_pop & ~o_empty;
    // When full, the write slot is the head being popped this cycle, so the
    // simultaneous case overwrites the departing entry and stays full.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule : dcim_sum_fifo

// File: rtl/dcim_psum_accumulator.sv
// Accumulates acc_len unsigned products per window and queues each window sum.
// Latency: sum visible one cycle after the completing sample (FIFO empty).
// Backpressure: 2-entry sum FIFO; a sum arriving when full without a pop is dropped and sets overrun.
// Ports: clk, rst_n scalar; bus (slave modport) carries enables, products, window length,
//        clear, and the sum_valid/sum_ready/sum_out/overrun/win_count outputs.
module dcim_psum_accumulator
    import dcim_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dcim_psum_accumulator_if.slave   bus
);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    acc_state_t           r_state, w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic [15:0]          r_win_count, w_win_count_nxt;

    logic                 w_accept;
    logic [LEN_WIDTH-1:0] w_eff_len;
    logic [LEN_WIDTH-1:0] w_cnt_inc;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_complete;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [ACC_WIDTH-1:0] w_fifo_dat;

    assign w_accept  = bus.valid_in & bus.pe_ce & bus.init_done & ~bus.acc_clear;
    assign w_eff_len = (bus.acc_len == '0)     ? LEN_ONE :
                       (bus.acc_len > LEN_MAX) ? LEN_MAX : bus.acc_len;
    assign w_cnt_inc = r_cnt + LEN_ONE;
    // First sample of a window starts from zero rather than a stale accumulator.
    assign w_sum     = ((r_state == ST_ACCUM) ? r_acc : '0) + ACC_WIDTH'(bus.product_in);
    assign w_pop     = ~w_empty & bus.sum_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_overrun   <= 1'b0;
            r_win_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_overrun   <= w_overrun_nxt;
            r_win_count <= w_win_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_overrun_nxt   = r_overrun;
        w_win_count_nxt = r_win_count;
        w_complete      = 1'b0;

        if (bus.acc_clear) begin
            // Flush wins over any same-cycle sample; win_count is left alone.
            w_state_nxt   = ST_IDLE;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_len_nxt     = '0;
            w_overrun_nxt = 1'b0;
        end else if ((r_state == ST_ACCUM) && !bus.init_done) begin
            // Upstream dropped out mid-window: the partial sum is meaningless.
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_len_nxt   = '0;
        end else if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_eff_len == LEN_ONE) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = w_sum;
                        w_cnt_nxt   = LEN_ONE;
                        w_len_nxt   = w_eff_len;
                    end
                end
                ST_ACCUM: begin
                    if (w_cnt_inc == r_len) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            if (w_complete) begin
                w_win_count_nxt = r_win_count + 16'd1;
                if (w_full && !w_pop) begin
                    w_overrun_nxt = 1'b1;
                end
            end
        end
    end

    dcim_sum_fifo #(
        .WIDTH (ACC_WIDTH)
    ) u_sum_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.acc_clear),
        .i_push  (w_complete),
        .i_pop   (w_pop),
        .i_data  (w_sum),
        .o_data  (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.sum_valid = ~w_empty;
    assign bus.sum_out   = w_fifo_dat;
    assign bus.overrun   = r_overrun;
    assign bus.win_count = r_win_count;

endmodule : dcim_psum_accumulator

// File: tb/tb_dcim_psum_accumulator.sv
// Directed bench for the partial-sum accumulator with a sum scoreboard.
// Latency: n/a.
// Backpressure: sum_ready driven by the bench.
module tb_dcim_psum_accumulator;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_err    = 0;
    int exp_wc   = 0;
    logic [39:0] sb [$];

    dcim_psum_accumulator_if bus ();

    dcim_psum_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p);
        bus.valid_in   = 1'b1;
        bus.product_in = p;
        step();
        bus.valid_in   = 1'b0;
    endtask

    // Send a window that completes: the expected sum is queued with the last sample.
    task automatic send_last(input logic [31:0] p, input logic [39:0] exp_sum);
        sb.push_back(exp_sum);
        exp_wc++;
        send(p);
    endtask

    // Scoreboard: a pop happens at the edge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (rst_n && bus.sum_valid && bus.sum_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                chk("sb_sum", 64'(bus.sum_out), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.pe_ce      = 1'b1;
        bus.init_done  = 1'b1;
        bus.valid_in   = 1'b0;
        bus.product_in = '0;
        bus.acc_len    = 6'd4;
        bus.acc_clear  = 1'b0;
        bus.sum_ready  = 1'b1;
        #2;
        chk("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
        chk("rst_sum_out",   64'(bus.sum_out),   64'd0);
        chk("rst_overrun",   64'(bus.overrun),   64'd0);
        chk("rst_win_count", 64'(bus.win_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Four-sample window: 1+2+3+4, valid for exactly one cycle.
        bus.acc_len = 6'd4;
        send(32'd1); send(32'd2); send(32'd3);
        chk("w4_not_yet", 64'(bus.sum_valid), 64'd0);
        send_last(32'd4, 40'd10);
        chk("w4_valid", 64'(bus.sum_valid), 64'd1);
        chk("w4_sum",   64'(bus.sum_out),   64'd10);
        chk("w4_wc",    64'(bus.win_count), 64'(exp_wc));
        step();
        chk("w4_one_cycle", 64'(bus.sum_valid), 64'd0);

        // Largest window of all-ones products.
        bus.acc_len = 6'd32;
        for (int i = 0; i < 31; i++) send(32'hFFFF_FFFF);
        send_last(32'hFFFF_FFFF, 40'h1F_FFFF_FFE0);
        chk("w32_sum", 64'(bus.sum_out), 64'h1F_FFFF_FFE0);
        step();
        chk("w32_wc", 64'(bus.win_count), 64'(exp_wc));

        // Overflow of the 2-entry FIFO with the consumer stalled.
        bus.sum_ready = 1'b0;
        bus.acc_len   = 6'd1;
        send_last(32'd5, 40'd5);
        send_last(32'd6, 40'd6);
        exp_wc++;
        send(32'd7);
        chk("ovr_flag",  64'(bus.overrun),   64'd1);
        chk("ovr_wc",    64'(bus.win_count), 64'(exp_wc));
        chk("ovr_head",  64'(bus.sum_out),   64'd5);
        step();
        chk("ovr_hold_valid", 64'(bus.sum_valid), 64'd1);
        chk("ovr_hold_sum",   64'(bus.sum_out),   64'd5);
        bus.sum_ready = 1'b1;
        step(); step();
        chk("ovr_drained", 64'(bus.sum_valid), 64'd0);
        bus.acc_clear = 1'b1;
        step();
        bus.acc_clear = 1'b0;
        chk("clr_overrun", 64'(bus.overrun),   64'd0);
        chk("clr_wc",      64'(bus.win_count), 64'(exp_wc));

        // Clear together with the completing sample discards the window.
        bus.acc_len = 6'd4;
        send(32'd1); send(32'd1); send(32'd1);
        bus.acc_clear  = 1'b1;
        bus.valid_in   = 1'b1;
        bus.product_in = 32'd1;
        step();
        bus.acc_clear = 1'b0;
        bus.valid_in  = 1'b0;
        chk("clr_no_out", 64'(bus.sum_valid), 64'd0);
        chk("clr_wc2",    64'(bus.win_count), 64'(exp_wc));
        send(32'd1); send(32'd1); send(32'd1);
        send_last(32'd1, 40'd4);
        step();

        // Push and pop on a full FIFO in the same cycle.
        bus.acc_len   = 6'd1;
        bus.sum_ready = 1'b0;
        send_last(32'd8, 40'd8);
        send_last(32'd9, 40'd9);
        bus.sum_ready = 1'b1;
        send_last(32'd10, 40'd10);
        chk("full_pp_overrun", 64'(bus.overrun), 64'd0);
        step(); step(); step();
        chk("full_pp_drained", 64'(bus.sum_valid), 64'd0);

        // Length is latched at the first sample of a window.
        bus.acc_len = 6'd4;
        send(32'd11); send(32'd12);
        bus.acc_len = 6'd2;
        send(32'd13);
        chk("len_latched", 64'(bus.sum_valid), 64'd0);
        send_last(32'd14, 40'd50);
        send(32'd20);
        send_last(32'd21, 40'd41);
        step();

        // init_done dropping mid-window abandons the partial sum.
        bus.acc_len = 6'd4;
        send(32'd1); send(32'd1);
        bus.init_done = 1'b0;
        step();
        bus.init_done = 1'b1;
        send(32'd2); send(32'd2); send(32'd2);
        send_last(32'd2, 40'd8);
        step();

        // pe_ce low holds the window; the sample offered meanwhile is ignored.
        send(32'd3);
        bus.pe_ce = 1'b0;
        send(32'd100);
        bus.pe_ce = 1'b1;
        send(32'd3); send(32'd3);
        send_last(32'd3, 40'd12);
        step();

        // acc_len = 0 acts as a single-sample window.
        bus.acc_len = 6'd0;
        send_last(32'd7, 40'd7);
        step();

        // acc_len above the maximum is clamped to 32.
        bus.acc_len = 6'd63;
        for (int i = 0; i < 31; i++) send(32'd1);
        chk("clamp_open", 64'(bus.sum_valid), 64'd0);
        send_last(32'd1, 40'd32);
        step();
        chk("final_wc", 64'(bus.win_count), 64'(exp_wc));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-window with one buffered sum.
        bus.sum_ready = 1'b0;
        bus.acc_len   = 6'd1;
        send(32'd42);
        bus.acc_len = 6'd4;
        send(32'd1); send(32'd1);
        chk("pre_rst_valid", 64'(bus.sum_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum_valid", 64'(bus.sum_valid), 64'd0);
        chk("arst_overrun",   64'(bus.overrun),   64'd0);
        chk("arst_win_count", 64'(bus.win_count), 64'd0);
        chk("arst_sum_out",   64'(bus.sum_out),   64'd0);
        sb.delete();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.sum_ready = 1'b1;
        step();
        chk("post_rst_valid", 64'(bus.sum_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_dcim_psum_accumulator
